// File: rtl/ccu_pkg.sv
// Shared types, constants and helpers for the CCU snoop scheduler.
// The optional perf counters are enabled with CCU_SNOOP_SCHED_PERF_EN.
package ccu_pkg;

   localparam int PerfCntWidth = 32;
   localparam int MaxAddrWidth = 64;
   localparam int MaxSlotWidth = 8;

   typedef logic [MaxSlotWidth-1:0] slot_idx_t;

   function automatic logic [MaxAddrWidth-1:0] line_addr(input logic [MaxAddrWidth-1:0] addr,
                                                         input int unsigned offset);
      return addr >> offset;
   endfunction

endpackage

// File: rtl/ccu_snoop_sched_if.sv
// Requester, grant and completion signals of the CCU snoop scheduler.
// slave is the scheduler side, master is the environment side.
interface ccu_snoop_sched_if #(
   parameter int NumReq    = 4,
   parameter int AddrWidth = 64,
   parameter int MaxTxns   = 4
);
   localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int SlotW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

   logic [NumReq-1:0]                req_valid_i;
   logic [NumReq-1:0]                req_ready_o;
   logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
   logic                             gnt_valid_o;
   logic                             gnt_ready_i;
   logic [AddrWidth-1:0]             gnt_addr_o;
   logic [IdxW-1:0]                  gnt_idx_o;
   logic [SlotW-1:0]                 gnt_slot_o;
   logic                             done_valid_i;
   logic [SlotW-1:0]                 done_slot_i;
   logic                             busy_o;

   modport slave (
      input  req_valid_i, req_addr_i, gnt_ready_i, done_valid_i, done_slot_i,
      output req_ready_o, gnt_valid_o, gnt_addr_o, gnt_idx_o, gnt_slot_o, busy_o
   );

   modport master (
      output req_valid_i, req_addr_i, gnt_ready_i, done_valid_i, done_slot_i,
      input  req_ready_o, gnt_valid_o, gnt_addr_o, gnt_idx_o, gnt_slot_o, busy_o
   );

endinterface

// File: rtl/ccu_rr_arb.sv
// Round-robin arbiter: searches from the index after the last winner.
// The pointer only moves in cycles where a grant is issued.
module ccu_rr_arb #(
   parameter int N    = 4,
   parameter int IdxW = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] gnt_idx
);

   logic [IdxW-1:0] ptr;

   always_comb begin
      int   idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IdxW'(idx);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
   end

endmodule

// File: rtl/ccu_snoop_tracker.sv
// In-flight transaction table: allocates the lowest free slot, frees on completion,
// and reports which requester lines collide with a live slot.
module ccu_snoop_tracker
   import ccu_pkg::*;
#(
   parameter int NumReq  = 4,
   parameter int MaxTxns = 4,
   parameter int LineW   = 58,
   parameter int SlotW   = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         alloc,
   input  logic [LineW-1:0]             alloc_line,
   input  logic                         free,
   input  logic [SlotW-1:0]             free_slot,
   input  logic [NumReq-1:0][LineW-1:0] query_line,
   output logic [NumReq-1:0]            match,
   output logic                         full,
   output logic                         any_valid,
   output logic [SlotW-1:0]             alloc_slot
);

   logic [MaxTxns-1:0]            valid;
   logic [MaxTxns-1:0][LineW-1:0] lines;

   always_comb begin
      match = '0;
      for (int r = 0; r < NumReq; r++) begin
         for (int s = 0; s < MaxTxns; s++) begin
            if (valid[s] && (lines[s] == query_line[r])) match[r] = 1'b1;
         end
      end
   end

   always_comb begin
      alloc_slot = '0;
      for (int s = MaxTxns - 1; s >= 0; s--) begin
         if (!valid[s]) alloc_slot = SlotW'(s);
      end
   end

   assign full      = &valid;
   assign any_valid = |valid;

   // A freed slot only becomes visible to match/full on the following cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         lines <= '0;
      end else begin
         if (free && valid[free_slot]) valid[free_slot] <= 1'b0;
         if (alloc) begin
            valid[alloc_slot] <= 1'b1;
            lines[alloc_slot] <= alloc_line;
         end
      end
   end

endmodule

// File: rtl/ccu_snoop_sched.sv
// Snoop scheduler: round-robin admission of requesters into one snoop FSM, with
// cacheline conflict blocking. Optional perf counters via CCU_SNOOP_SCHED_PERF_EN.
module ccu_snoop_sched
   import ccu_pkg::*;
#(
   parameter int NumReq     = 4,
   parameter int AddrWidth  = 64,
   parameter int MaxTxns    = 4,
   parameter int LineOffset = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   ccu_snoop_sched_if.slave        bus
`ifdef CCU_SNOOP_SCHED_PERF_EN
   ,
   output logic [PerfCntWidth-1:0] perf_conflict_cnt_o,
   output logic [PerfCntWidth-1:0] perf_full_cnt_o
`endif
);

   localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int SlotW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
   localparam int LineW = AddrWidth - LineOffset;

   logic [NumReq-1:0][LineW-1:0] req_line;
   logic [NumReq-1:0]            match;
   logic [NumReq-1:0]            eligible;
   logic [NumReq-1:0]            grant;
   logic [IdxW-1:0]              win_idx;
   logic [SlotW-1:0]             alloc_slot;
   logic                         full;
   logic                         any_valid;
   logic                         can_accept;
   logic                         accept;

   always_comb begin
      req_line = '0;
      for (int r = 0; r < NumReq; r++) begin
         req_line[r] = LineW'(line_addr(MaxAddrWidth'(bus.req_addr_i[r]), LineOffset));
      end
   end

   assign can_accept = ~bus.gnt_valid_o | bus.gnt_ready_i;
   assign eligible   = bus.req_valid_i & ~match & {NumReq{~full & can_accept & ~rst_i}};
   assign accept     = |grant;
   assign bus.req_ready_o = grant;
   assign bus.busy_o      = any_valid | bus.gnt_valid_o;

   ccu_rr_arb #(.N(NumReq), .IdxW(IdxW)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req     (eligible),
      .gnt     (grant),
      .gnt_idx (win_idx)
   );

   ccu_snoop_tracker #(
      .NumReq  (NumReq),
      .MaxTxns (MaxTxns),
      .LineW   (LineW),
      .SlotW   (SlotW)
   ) u_tracker (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .alloc      (accept),
      .alloc_line (req_line[win_idx]),
      .free       (bus.done_valid_i),
      .free_slot  (bus.done_slot_i),
      .query_line (req_line),
      .match      (match),
      .full       (full),
      .any_valid  (any_valid),
      .alloc_slot (alloc_slot)
   );

   // A new acceptance overwrites the register only when it is empty or draining.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus.gnt_valid_o <= 1'b0;
         bus.gnt_addr_o  <= '0;
         bus.gnt_idx_o   <= '0;
         bus.gnt_slot_o  <= '0;
      end else if (accept) begin
         bus.gnt_valid_o <= 1'b1;
         bus.gnt_addr_o  <= bus.req_addr_i[win_idx];
         bus.gnt_idx_o   <= win_idx;
         bus.gnt_slot_o  <= alloc_slot;
      end else if (bus.gnt_ready_i) begin
         bus.gnt_valid_o <= 1'b0;
      end
   end

`ifdef CCU_SNOOP_SCHED_PERF_EN
   logic conflict_seen;
   logic full_seen;

   assign conflict_seen = |(bus.req_valid_i & match);
   assign full_seen     = (|bus.req_valid_i) & full;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_conflict_cnt_o <= '0;
         perf_full_cnt_o     <= '0;
      end else begin
         if (conflict_seen && !(&perf_conflict_cnt_o))
            perf_conflict_cnt_o <= perf_conflict_cnt_o + PerfCntWidth'(1);
         if (full_seen && !(&perf_full_cnt_o))
            perf_full_cnt_o <= perf_full_cnt_o + PerfCntWidth'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ccu_snoop_sched.sv
// Randomized and directed bench for ccu_snoop_sched against a transaction-level model.
// Also checks the perf counters when CCU_SNOOP_SCHED_PERF_EN is defined.
module tb_ccu_snoop_sched;

   localparam int NumReq     = 4;
   localparam int AddrWidth  = 32;
   localparam int MaxTxns    = 2;
   localparam int LineOffset = 6;
   localparam int SlotW      = 1;

   typedef logic [NumReq-1:0][AddrWidth-1:0] addr_vec_t;

   logic clk_i = 1'b0;
   logic rst_i;

   always #5 clk_i = ~clk_i;

   ccu_snoop_sched_if #(.NumReq(NumReq), .AddrWidth(AddrWidth), .MaxTxns(MaxTxns)) bus ();

`ifdef CCU_SNOOP_SCHED_PERF_EN
   logic [31:0] perf_conflict_cnt_o;
   logic [31:0] perf_full_cnt_o;
`endif

   ccu_snoop_sched #(
      .NumReq     (NumReq),
      .AddrWidth  (AddrWidth),
      .MaxTxns    (MaxTxns),
      .LineOffset (LineOffset)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
`ifdef CCU_SNOOP_SCHED_PERF_EN
      ,
      .perf_conflict_cnt_o (perf_conflict_cnt_o),
      .perf_full_cnt_o     (perf_full_cnt_o)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a set of live cachelines, one pending grant, and the next search start.
   bit          mValid[MaxTxns];
   logic [31:0] mLine[MaxTxns];
   bit          mGntValid;
   logic [31:0] mGntAddr;
   int          mGntIdx;
   int          mGntSlot;
   int          mPtr;
   longint      mConf;
   longint      mFull;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int s = 0; s < MaxTxns; s++) begin
         mValid[s] = 0;
         mLine[s]  = '0;
      end
      mGntValid = 0;
      mGntAddr  = '0;
      mGntIdx   = 0;
      mGntSlot  = 0;
      mPtr      = 0;
      mConf     = 0;
      mFull     = 0;
   endtask

   task automatic driveIdle();
      bus.req_valid_i  = '0;
      bus.req_addr_i   = '0;
      bus.gnt_ready_i  = 1'b0;
      bus.done_valid_i = 1'b0;
      bus.done_slot_i  = '0;
   endtask

   // Asserts reset in the middle of a cycle and checks every output drops at once.
   task automatic doReset(input string tag);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput({tag, "_req_ready"}, bus.req_ready_o, 0);
      checkOutput({tag, "_gnt_valid"}, bus.gnt_valid_o, 0);
      checkOutput({tag, "_gnt_addr"}, bus.gnt_addr_o, 0);
      checkOutput({tag, "_gnt_idx"}, bus.gnt_idx_o, 0);
      checkOutput({tag, "_gnt_slot"}, bus.gnt_slot_o, 0);
      checkOutput({tag, "_busy"}, bus.busy_o, 0);
`ifdef CCU_SNOOP_SCHED_PERF_EN
      checkOutput({tag, "_perf_conflict"}, perf_conflict_cnt_o, 0);
      checkOutput({tag, "_perf_full"}, perf_full_cnt_o, 0);
`endif
      driveIdle();
      modelReset();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Drives one cycle of inputs, checks the DUT against the model, then advances the model.
   task automatic applyStimulus(input logic [NumReq-1:0] valid, input addr_vec_t addrs,
                                input bit gready, input bit dvalid, input int dslot);
      bit   full;
      bit   canAcc;
      bit   hit[NumReq];
      bit   blockedConf;
      bit   blockedFull;
      bit   nValid[MaxTxns];
      int   winner;
      int   slot;
      int   r;

      @(negedge clk_i);
      bus.req_valid_i  = valid;
      bus.req_addr_i   = addrs;
      bus.gnt_ready_i  = gready;
      bus.done_valid_i = dvalid;
      bus.done_slot_i  = SlotW'(dslot);
      #1;

      full = 1;
      for (int s = 0; s < MaxTxns; s++) if (!mValid[s]) full = 0;
      canAcc      = !mGntValid || gready;
      blockedConf = 0;
      blockedFull = 0;
      for (int q = 0; q < NumReq; q++) begin
         hit[q] = 0;
         for (int s = 0; s < MaxTxns; s++)
            if (mValid[s] && mLine[s] == (addrs[q] >> LineOffset)) hit[q] = 1;
         if (valid[q] && hit[q]) blockedConf = 1;
         if (valid[q] && full) blockedFull = 1;
      end
      winner = -1;
      if (canAcc && !full) begin
         for (int k = 0; k < NumReq; k++) begin
            r = (mPtr + k) % NumReq;
            if (winner < 0 && valid[r] && !hit[r]) winner = r;
         end
      end

      checkOutput("req_ready", bus.req_ready_o, (winner >= 0) ? (64'd1 << winner) : 64'd0);
      checkOutput("gnt_valid", bus.gnt_valid_o, mGntValid);
      if (mGntValid) begin
         checkOutput("gnt_addr", bus.gnt_addr_o, mGntAddr);
         checkOutput("gnt_idx", bus.gnt_idx_o, mGntIdx);
         checkOutput("gnt_slot", bus.gnt_slot_o, mGntSlot);
      end
      checkOutput("busy", bus.busy_o, (mValid.or() != 0) || mGntValid);
`ifdef CCU_SNOOP_SCHED_PERF_EN
      checkOutput("perf_conflict", perf_conflict_cnt_o, mConf);
      checkOutput("perf_full", perf_full_cnt_o, mFull);
`endif

      nValid = mValid;
      if (dvalid && mValid[dslot]) nValid[dslot] = 0;
      if (mGntValid && gready) mGntValid = 0;
      if (winner >= 0) begin
         slot = -1;
         for (int s = 0; s < MaxTxns; s++) if (slot < 0 && !mValid[s]) slot = s;
         nValid[slot] = 1;
         mLine[slot]  = addrs[winner] >> LineOffset;
         mGntValid    = 1;
         mGntAddr     = addrs[winner];
         mGntIdx      = winner;
         mGntSlot     = slot;
         mPtr         = (winner + 1) % NumReq;
      end
      mValid = nValid;
      if (blockedConf) mConf++;
      if (blockedFull) mFull++;
   endtask

   task automatic drain();
      addr_vec_t none;
      none = '0;
      for (int i = 0; i < 4; i++) applyStimulus('0, none, 1'b1, 1'b1, i % MaxTxns);
   endtask

   initial begin
      addr_vec_t   addrs;
      logic [31:0] pool[4];

      rst_i = 1'b1;
      driveIdle();
      modelReset();
      #1;
      checkOutput("init_gnt_valid", bus.gnt_valid_o, 0);
      checkOutput("init_busy", bus.busy_o, 0);
      checkOutput("init_req_ready", bus.req_ready_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Round-robin over all four requesters with completions right behind the grants.
      for (int q = 0; q < NumReq; q++) addrs[q] = 32'h1000 * (q + 1);
      for (int i = 0; i < 6; i++) applyStimulus(4'b1111, addrs, 1'b1, mGntValid, mGntSlot);
      drain();

      // Same-line request waits for the owning slot to complete.
      addrs = '0;
      addrs[0] = 32'h1000;
      addrs[1] = 32'h1038;
      applyStimulus(4'b0001, addrs, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0010, addrs, 1'b1, 1'b0, 0);
      applyStimulus(4'b0010, addrs, 1'b1, 1'b1, 0);
      applyStimulus(4'b0010, addrs, 1'b1, 1'b0, 0);
      drain();

      // Full tracker blocks every requester until a completion.
      addrs = '0;
      addrs[0] = 32'h5000;
      addrs[1] = 32'h6000;
      addrs[2] = 32'h2000;
      applyStimulus(4'b0011, addrs, 1'b1, 1'b0, 0);
      applyStimulus(4'b0011, addrs, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0100, addrs, 1'b1, 1'b0, 0);
      applyStimulus(4'b0100, addrs, 1'b1, 1'b1, 1);
      applyStimulus(4'b0100, addrs, 1'b1, 1'b0, 0);
      drain();

      // Stalled grant holds its payload and blocks further acceptance.
      for (int q = 0; q < NumReq; q++) addrs[q] = 32'h8000 + 32'h100 * q;
      applyStimulus(4'b1111, addrs, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(4'b1111, addrs, 1'b0, 1'b0, 0);
      applyStimulus(4'b0000, addrs, 1'b1, 1'b0, 0);
      drain();

      // Reset with two live slots and a pending grant, then restart from slot 0 / idx 0.
      for (int q = 0; q < NumReq; q++) addrs[q] = 32'h9000 + 32'h40 * q;
      applyStimulus(4'b1111, addrs, 1'b1, 1'b0, 0);
      applyStimulus(4'b1111, addrs, 1'b1, 1'b0, 0);
      bus.req_valid_i = 4'b1111;
      doReset("rst");
      applyStimulus(4'b1111, addrs, 1'b0, 1'b0, 0);
      applyStimulus(4'b0000, addrs, 1'b1, 1'b0, 0);
      drain();

      // Completion naming a free slot changes nothing.
      applyStimulus(4'b0000, addrs, 1'b1, 1'b1, 1);
      applyStimulus(4'b0000, addrs, 1'b1, 1'b0, 0);

      pool[0] = 32'h1000;
      pool[1] = 32'h1040;
      pool[2] = 32'h2000;
      pool[3] = 32'h3000;
      for (int i = 0; i < 400; i++) begin
         for (int q = 0; q < NumReq; q++)
            addrs[q] = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 63));
         applyStimulus(4'($urandom_range(0, 15)), addrs, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0, int'($urandom_range(0, MaxTxns - 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ccu_snoop_sched.md
CCU_SNOOP_SCHED -- requirements
Module: ccu_snoop_sched

Interface
- REQ-001 SHALL have parameter NumReq, default 4: number of requester ports (slave-port groups) sharing one snoop FSM.
- REQ-002 SHALL have parameter AddrWidth, default 64: request address width.
- REQ-003 SHALL have parameter MaxTxns, default 4: number of in-flight transaction tracker slots.
- REQ-004 SHALL have parameter LineOffset, default 6: log2 of cacheline bytes; address bits below it are ignored for conflict checks.
- REQ-005 SHALL have port clk_i, input, 1: the only clock; all state is on its rising edge.
- REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
- REQ-007 SHALL have port req_valid_i, input, NumReq: per-requester request valid.
- REQ-008 SHALL have port req_ready_o, output, NumReq: per-requester accept, one-hot or zero.
- REQ-009 SHALL have port req_addr_i, input, NumReq x AddrWidth: per-requester request address.
- REQ-010 SHALL have port gnt_valid_o, input-side handshake to the snoop FSM, output, 1: granted request valid.
- REQ-011 SHALL have port gnt_ready_i, input, 1: snoop FSM accepts the grant.
- REQ-012 SHALL have port gnt_addr_o, output, AddrWidth: granted address.
- REQ-013 SHALL have port gnt_idx_o, output, clog2(NumReq): granted requester index.
- REQ-014 SHALL have port gnt_slot_o, output, clog2(MaxTxns): tracker slot bound to the grant.
- REQ-015 SHALL have port done_valid_i, input, 1: pulse marking completion of one transaction.
- REQ-016 SHALL have port done_slot_i, input, clog2(MaxTxns): slot of the completed transaction.
- REQ-017 SHALL have port busy_o, output, 1: any tracker slot valid or gnt_valid_o high.

Function
- REQ-018 SHALL treat a requester as eligible when req_valid_i is high, its line address (addr >> LineOffset) matches no valid tracker slot, and at least one slot is free.
- REQ-019 SHALL choose among eligible requesters round-robin, starting at the index after the last winner (reset pointer 0).
- REQ-020 SHALL assert req_ready_o for the winner only when the output register is empty or drained this cycle (gnt_valid_o & gnt_ready_i).
- REQ-021 SHALL, on req_valid & req_ready, load the output register, allocate the lowest-numbered free slot with the line address, and drive gnt_valid_o high on the next cycle (latency 1, throughput 1 per cycle).
- REQ-022 SHALL hold gnt_valid_o, gnt_addr_o, gnt_idx_o and gnt_slot_o stable until gnt_ready_i is sampled high.
- REQ-023 SHALL, on done_valid_i, clear slot done_slot_i; the freed slot and its address become usable from the next cycle, not the same cycle.
- REQ-024 SHALL ignore done_valid_i naming an already-invalid slot.
- REQ-025 SHALL, when all slots are valid, deassert all req_ready_o irrespective of addresses.
- REQ-026 SHALL, when two requesters present the same line in one cycle, grant only one; the other then conflicts with the new slot.
- REQ-027 SHALL leave the round-robin pointer unchanged in cycles with no acceptance.

Reset
- REQ-028 SHALL, on rst_i, clear all tracker slots, the output register and the pointer: req_ready_o=0, gnt_valid_o=0, gnt_addr_o=0, gnt_idx_o=0, gnt_slot_o=0, busy_o=0, regardless of in-flight transactions.

Configuration
- REQ-029 SHALL, with CCU_SNOOP_SCHED_PERF_EN defined, add outputs perf_conflict_cnt_o and perf_full_cnt_o (32 bits each, saturating, reset 0), counting cycles with a valid request blocked by address conflict, respectively by a full tracker.
- REQ-030 SHALL, without CCU_SNOOP_SCHED_PERF_EN, omit those ports and counters entirely.

Structure
- REQ-031 SHALL place the slot index type, line-address helper function and perf counter width constant in ccu_pkg.
- REQ-032 SHALL implement the tracker table (allocate, free, match vector) as sub-module ccu_snoop_tracker; arbitration uses the existing round-robin arbiter primitive.

Verification (NumReq=4, MaxTxns=2, LineOffset=6)
- REQ-033 SHALL cover: req_valid_i=4'b1111, distinct lines, gnt_ready_i=1, done after each grant -> grants idx 0,1,2,3,0 in order.
- REQ-034 SHALL cover: req0 addr 0x1000 granted, req1 addr 0x1038 -> req1 blocked until done_slot 0, granted one cycle after done.
- REQ-035 SHALL cover: two grants outstanding, req2 addr 0x2000 -> req_ready_o=0 until a done; perf_full_cnt_o increments each blocked cycle when macro defined.
- REQ-036 SHALL cover: gnt_ready_i=0 for 5 cycles -> gnt_* outputs constant, no further req_ready_o.
- REQ-037 SHALL cover: rst_i asserted with 2 slots valid and gnt_valid_o=1 -> all outputs 0 immediately; first post-reset grant gets slot 0, idx 0.
- REQ-038 SHALL cover: done_valid_i on invalid slot 1 -> no state change, busy_o unchanged.
